// File: rtl/bitheap_shift_loader.sv
// Serial loader for the N x N multiplier bit heap: per-column shift registers,
// fill counter, start / valid-ready / heap handshake. Define BITHEAP_REF_SUM_EN for ref_sum_o.
module bitheap_shift_loader #(
  parameter int N    = 11,
  parameter int SUMW = 2 * N
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*N-2:0]       src_in_i,
  output logic [N*N-1:0]       heap_o,
  output logic                 heap_valid_o,
  input  logic                 heap_ready_i,
  output logic                 busy_o
`ifdef BITHEAP_REF_SUM_EN
  ,
  output logic [SUMW-1:0]      ref_sum_o
`endif
);

  localparam int COLS = 2 * N - 1;
  localparam int NB   = N * N;
  localparam int CW   = $clog2(N + 1);

  function automatic int col_h(input int c);
    return (c + 1 < COLS - c) ? c + 1 : COLS - c;
  endfunction

  function automatic int col_off(input int c);
    int s;
    s = 0;
    for (int k = 0; k < c; k++) s += col_h(k);
    return s;
  endfunction

  function automatic int bit_col(input int i);
    int acc;
    int r;
    acc = 0;
    r   = 0;
    for (int c = 0; c < COLS; c++) begin
      if (i >= acc) r = c;
      acc += col_h(c);
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]   heap_q, heap_d;
  logic [NB-1:0]   heap_shift;

  // Handshake: a src beat transfers on a cycle where in_valid_i && in_ready_o;
  // the heap is offered while heap_valid_o and released on a cycle with heap_ready_i.

  // The heap register is the set of column shift registers; bit 0 of each column is newest.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int H   = col_h(c);
    localparam int OFF = col_off(c);
    if (H == 1) begin : g_single
      assign heap_shift[OFF] = src_in_i[c];
    end else begin : g_multi
      assign heap_shift[OFF +: H] = {heap_q[OFF +: H-1], src_in_i[c]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    heap_d  = heap_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (in_valid_i) begin
          heap_d = heap_shift;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (heap_ready_i) begin
          if (start_i) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      heap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      heap_q  <= heap_d;
    end
  end

  assign in_ready_o   = (state_q == S_FILL);
  assign heap_valid_o = (state_q == S_HOLD);
  assign busy_o       = (state_q != S_IDLE);
  assign heap_o       = heap_q;

`ifdef BITHEAP_REF_SUM_EN
  logic [SUMW-1:0] term [NB];
  logic [SUMW-1:0] ref_sum_q, ref_sum_d;
  logic            enter_hold;

  // Each heap bit carries the weight 2^column; summed from the heap being loaded.
  for (genvar i = 0; i < NB; i++) begin : g_term
    localparam int BC = bit_col(i);
    assign term[i] = heap_shift[i] ? (SUMW'(1) << BC) : '0;
  end

  always_comb begin
    ref_sum_d = '0;
    for (int i = 0; i < NB; i++) ref_sum_d = ref_sum_d + term[i];
  end

  assign enter_hold = (state_q == S_FILL) && in_valid_i && (cnt_q == CW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_sum_q <= '0;
    end else if (enter_hold) begin
      ref_sum_q <= ref_sum_d;
    end
  end

  assign ref_sum_o = ref_sum_q;
`endif

endmodule

// File: tb/tb_bitheap_shift_loader.sv
// Bench for bitheap_shift_loader at N=3: directed scenarios plus random traffic,
// checked every cycle against a beat-history model of the heap.
module tb_bitheap_shift_loader;

  localparam int N    = 3;
  localparam int COLS = 2 * N - 1;
  localparam int NB   = N * N;
  localparam int SUMW = 2 * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [COLS-1:0]   src;
  logic [NB-1:0]     heap;
  logic              heap_valid;
  logic              heap_ready;
  logic              busy;
`ifdef BITHEAP_REF_SUM_EN
  logic [SUMW-1:0]   ref_sum;
`endif

  bitheap_shift_loader #(.N(N), .SUMW(SUMW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .src_in_i     (src),
    .heap_o       (heap),
    .heap_valid_o (heap_valid),
    .heap_ready_i (heap_ready),
    .busy_o       (busy)
`ifdef BITHEAP_REF_SUM_EN
    ,
    .ref_sum_o    (ref_sum)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The heap is a pure function of the last N accepted beats since the last reset.
  logic [COLS-1:0] hist[$];
  int              phase;     // 0 idle, 1 fill, 2 hold
  int              beats;
  longint          m_sum;
  bit              model_ok = 1'b0;

  function automatic int col_h(input int c);
    return (c + 1 < COLS - c) ? c + 1 : COLS - c;
  endfunction

  function automatic int col_off(input int c);
    int s;
    s = 0;
    for (int k = 0; k < c; k++) s += col_h(k);
    return s;
  endfunction

  function automatic logic [NB-1:0] model_heap();
    logic [NB-1:0] h;
    h = '0;
    for (int c = 0; c < COLS; c++)
      for (int j = 0; j < col_h(c); j++)
        if (j < hist.size()) h[col_off(c) + j] = hist[j][c];
    return h;
  endfunction

  function automatic longint model_sum();
    longint s;
    s = 0;
    for (int c = 0; c < COLS; c++)
      for (int j = 0; j < col_h(c) && j < hist.size(); j++)
        if (hist[j][c]) s += (longint'(1) << c);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      beats = 0;
      m_sum = 0;
      hist.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      case (phase)
        0: if (start) begin phase = 1; beats = 0; end
        1: if (in_valid) begin
          hist.push_front(src);
          if (hist.size() > N) void'(hist.pop_back());
          beats++;
          if (beats == N) begin
            phase = 2;
            m_sum = model_sum();
          end
        end
        default: if (heap_ready) begin
          phase = start ? 1 : 0;
          beats = 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("in_ready", 64'(in_ready), 64'(phase == 1));
      check("heap_valid", 64'(heap_valid), 64'(phase == 2));
      check("busy", 64'(busy), 64'(phase != 0));
      check("heap", 64'(heap), 64'(model_heap()));
`ifdef BITHEAP_REF_SUM_EN
      check("ref_sum", 64'(ref_sum), 64'(m_sum));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic release_heap();
    heap_ready = 1'b1;
    cyc();
    heap_ready = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int pat[5];
    pat = '{1, 0, 0, 1, 1};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; heap_ready = 1'b0; src = '0;
    cyc();
    cyc();
    rst = 1'b0;

    // reset values
    check("rst_heap", 64'(heap), 64'(0));
    check("rst_heap_valid", 64'(heap_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
`ifdef BITHEAP_REF_SUM_EN
    check("rst_ref_sum", 64'(ref_sum), 64'(0));
`endif

    // all-ones fill: heap_valid appears after the third beat
    do_start();
    in_valid = 1'b1;
    src = '1;
    cyc();
    check("ones_hv_b1", 64'(heap_valid), 64'(0));
    cyc();
    check("ones_hv_b2", 64'(heap_valid), 64'(0));
    cyc();
    in_valid = 1'b0;
    check("ones_hv_b3", 64'(heap_valid), 64'(1));
    check("ones_heap", 64'(heap), 64'h1FF);
`ifdef BITHEAP_REF_SUM_EN
    check("ones_ref_sum", 64'(ref_sum), 64'(49));
`endif
    release_heap();
    check("ones_idle", 64'(busy), 64'(0));

    // ordering: column 2 receives 1,0,0 -> oldest bit at top of column
    do_start();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src = COLS'($urandom);
      src[2] = (k == 0);
      cyc();
    end
    in_valid = 1'b0;
    check("order_bit5", 64'(heap[5]), 64'(1));
    check("order_bit4", 64'(heap[4]), 64'(0));
    check("order_bit3", 64'(heap[3]), 64'(0));
    release_heap();

    // stalls: valid pattern 1,0,0,1,1
    do_start();
    for (int k = 0; k < 5; k++) begin
      in_valid = pat[k][0];
      src = COLS'($urandom);
      cyc();
      if (k == 3) check("stall_hv_early", 64'(heap_valid), 64'(0));
    end
    in_valid = 1'b0;
    check("stall_hv", 64'(heap_valid), 64'(1));

    // backpressure: beats and start ignored while heap_ready is low
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      src = COLS'($urandom);
      start = ($urandom_range(0, 1) == 1);
      cyc();
      check("bp_hv", 64'(heap_valid), 64'(1));
    end
    in_valid = 1'b0;
    start = 1'b0;

    // back-to-back release and restart
    heap_ready = 1'b1;
    start = 1'b1;
    cyc();
    heap_ready = 1'b0;
    start = 1'b0;
    check("b2b_in_ready", 64'(in_ready), 64'(1));
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_hv", 64'(heap_valid), 64'(0));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src = COLS'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    check("b2b_done", 64'(heap_valid), 64'(1));
    release_heap();

    // reset mid-fill discards partial heap
    do_start();
    in_valid = 1'b1;
    src = '1;
    cyc();
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_heap", 64'(heap), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    do_start();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src = COLS'($urandom);
      cyc();
      check("mid_rst_hv", 64'(heap_valid), 64'(k == 2));
    end
    in_valid = 1'b0;
    release_heap();

    // random traffic
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      start      = ($urandom_range(0, 3) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      heap_ready = ($urandom_range(0, 2) == 0);
      src        = COLS'($urandom);
      cyc();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; heap_ready = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
